// File: rtl/serial_rr_scheduler_pkg.sv
// Shared types and widths for the serial round-robin scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package serial_rr_scheduler_pkg;

  localparam int NUM_REQ_DEF   = 2;
  localparam int FRAME_LEN_DEF = 8;
  localparam int DEPTH_DEF     = 2;

  // Widths track the package defaults; retune them together with the top parameters.
  localparam int ID_W  = $clog2(NUM_REQ_DEF);
  localparam int CNT_W = $clog2(FRAME_LEN_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            last;
  } tag_t;

endpackage

// File: rtl/serial_rr_scheduler_if.sv
// Requester, datapath and tagged-output signals of the serial scheduler.
// Latency: none (wiring only).
// Backpressure: req is a level held until gnt; the serial side has none.
interface serial_rr_scheduler_if
  import serial_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*FRAME_LEN-1:0] frame_data;
  logic [NUM_REQ-1:0]           gnt;
  logic                         busy;
  logic                         a;
  logic                         y;
  logic                         out_bit;
  logic                         out_valid;
  logic [ID_W-1:0]              out_id;
  logic                         out_last;

  modport slave (
    input  req, frame_data, y,
    output gnt, busy, a, out_bit, out_valid, out_id, out_last
  );

  modport master (
    output req, frame_data, y,
    input  gnt, busy, a, out_bit, out_valid, out_id, out_last
  );

endinterface

// File: rtl/serial_rr_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted req at or above ptr, wrapping; one-hot plus index.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is taken.
module serial_rr_scheduler_rr_arbiter
  import serial_rr_scheduler_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/serial_rr_scheduler.sv
// Shares one serial delay line among requesters: grant, serialise LSB-first, tag returning bits.
// Latency: bit j on a at grant+1+j; its tag on out_* at grant+1+j+DEPTH.
// Backpressure: req held until a one-cycle gnt; requests are ignored while busy.
module serial_rr_scheduler
  import serial_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_rr_scheduler_if.slave  bus
);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      id_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [FRAME_LEN-1:0] shreg_q;
  logic                 a_q;
  tag_t                 a_tag_q;
  tag_t                 pipe_q [DEPTH];

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;
  logic [NUM_REQ-1:0]   gnt;
  logic                 take;
  logic                 last_bit;
  logic [FRAME_LEN-1:0] sel_frame;
  logic [ID_W-1:0]      ptr_next;

  serial_rr_scheduler_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign take      = (state_q == IDLE) && arb_any;
  assign last_bit  = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign sel_frame = bus.frame_data[int'(arb_idx)*FRAME_LEN +: FRAME_LEN];
  assign ptr_next  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  // Next state and the combinational grant pulse, issued only from IDLE.
  always_comb begin
    state_d = state_q;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt     = arb_gnt;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_bit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, serialiser and tag pipeline; a and its tag are loaded on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      a_q     <= 1'b0;
      a_tag_q <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pipe_q[0] <= a_tag_q;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      if (take) begin
        a_q     <= sel_frame[0];
        shreg_q <= sel_frame >> 1;
        id_q    <= arb_idx;
        ptr_q   <= ptr_next;
        cnt_q   <= '0;
        a_tag_q <= '{valid: 1'b1, id: arb_idx, last: 1'b0};
      end else if (state_q == SEND && !last_bit) begin
        a_q     <= shreg_q[0];
        shreg_q <= shreg_q >> 1;
        cnt_q   <= cnt_q + 1'b1;
        a_tag_q <= '{valid: 1'b1, id: id_q,
                     last: (cnt_q == CNT_W'(FRAME_LEN - 2))};
      end else begin
        a_q     <= 1'b0;
        cnt_q   <= '0;
        a_tag_q <= '0;
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.busy      = (state_q == SEND);
  assign bus.a         = a_q;
  assign bus.out_bit   = bus.y;
  assign bus.out_valid = pipe_q[DEPTH-1].valid;
  assign bus.out_id    = pipe_q[DEPTH-1].id;
  assign bus.out_last  = pipe_q[DEPTH-1].last;

endmodule

// File: doc/serial_rr_scheduler.md
Name: serial_rr_scheduler

Overview:
Round-robin scheduler that shares one single-bit serial delay-line datapath (the two-flop non-blocking pipeline, fixed latency DEPTH) between NUM_REQ requesters. It grants one requester at a time, latches its parallel frame, and serialises it LSB-first onto the datapath input `a`. It tags the returning bits on `y` with valid, requester id and last-bit flags aligned to the datapath latency. The block sits between the requesters and the delay line; the delay line stays external and unmodified.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
FRAME_LEN, 8, bits per frame (>=2)
DEPTH, 2, datapath latency in clock edges from `a` sampled to `y` valid (>=1)

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request, level, held until granted
frame_data  input  NUM_REQ*FRAME_LEN  parallel frames, requester i at slice [i*FRAME_LEN +: FRAME_LEN]
gnt  output  NUM_REQ  one-hot, one-cycle pulse; frame of granted requester sampled this cycle
busy  output  1  high while SEND state active
a  output  1  serial bit to datapath input (registered)
y  input  1  serial bit from datapath output
out_bit  output  1  equals y (combinational pass-through)
out_valid  output  1  y carries a frame bit this cycle
out_id  output  clog2(NUM_REQ)  requester owning current out_bit
out_last  output  1  out_bit is bit FRAME_LEN-1 of its frame

Behaviour:
- Reset (sync, any state): state=IDLE, a=0, gnt=0, busy=0, bit counter=0, rr pointer=0 (requester 0 highest priority next), tag pipeline cleared → out_valid=0, out_id=0, out_last=0 on the following cycle. Frame in flight is aborted; no partial out_last is produced.
- FSM states: IDLE, SEND.
- IDLE: if |req, pick first asserted requester searching from rr pointer upward with wrap. Assert gnt[k] combinationally in this cycle, latch frame_data slice k into shift register, latch id k, set rr pointer=(k+1) mod NUM_REQ, go SEND. If no req, stay IDLE, a=0.
- SEND: a registered from shift register LSB; one bit per cycle for exactly FRAME_LEN cycles; counter 0..FRAME_LEN-1, width clog2(FRAME_LEN). After last bit, go IDLE. Requests arriving during SEND are ignored until IDLE. Minimum inter-frame gap = 1 cycle (grant cycle, a=0).
- Timing: grant at cycle g → bit j on `a` during cycle g+1+j → same bit on `y` during cycle g+1+j+DEPTH.
- Tag pipeline: DEPTH-stage shift of {valid,id,last}, pushed in parallel with `a`; stage output drives out_valid/out_id/out_last. Idle cycles push valid=0.
- req dropped before grant: not granted, no effect. frame_data changes after gnt: no effect.
- Simultaneous reqs: strict round robin; with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- No combinational path from y to any registered state.

Decomposition:
- Shared package: state enum (IDLE, SEND), tag struct {valid, id, last}, ID_W = clog2(NUM_REQ), CNT_W = clog2(FRAME_LEN).
- One sub-module: rr_arbiter (req vector + pointer → one-hot grant + index), reusable elsewhere. Tag pipeline stays inline.

Test Plan:
Bench instantiates block with the two-flop delay line (DEPTH=2), NUM_REQ=2, FRAME_LEN=8.
- Reset, req=2'b01, frame0=8'hA5 → gnt=2'b01 one cycle (g); a = 1,0,1,0,0,1,0,1 over g+1..g+8; out_valid at g+3..g+10, out_id=0, out_last only at g+10, out_bit matches.
- req=2'b11 held continuously, frame0=8'hFF, frame1=8'h00 → grants alternate 0,1,0,1; each frame 8 bits with 1-cycle gap; out_id switches correctly at frame boundaries.
- Only req[1] asserted after reset → granted immediately despite rr pointer=0; next simultaneous request grants 0 first.
- Reset asserted at 4th SEND bit → next cycle state IDLE, a=0, busy=0; out_valid=0 one cycle after reset; no out_last emitted for aborted frame.
- req[0] pulsed for one cycle during SEND of requester 1, then dropped → never granted; frame_data changed mid-SEND → transmitted bits unchanged.
- No req for 20 cycles → a=0, gnt=0, out_valid=0 throughout.
